// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encodings and arbitration mode constants for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between two requesters (0 = m0, 1 = m1)
module mem_arb_pick import mem_arbiter_pkg::*; #(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int STARVE_MAX = 4,
  parameter int SW = 3
) (
  input  logic          stb0,
  input  logic          stb1,
  input  logic          last_gnt,
  input  logic [SW-1:0] starve_cnt,
  output logic          win
);
  assign win = !stb0 ? 1'b1 : !stb1 ? 1'b0 :
               (PRIO_MODE == PRIO_FIXED) ? (starve_cnt == SW'(STARVE_MAX)) : ~last_gnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master Wishbone arbiter sharing one memory controller port, with timeout and post-ack stb gap
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [19:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic        m0_byte_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [19:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic        m1_byte_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [19:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic        s_we_o,
  output logic        s_byte_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  output logic        gnt_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);
  state_t        state;
  logic          last_gnt;
  logic          win;
  logic          stb_g;
  logic          in_grant;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wdog;
  logic [1:0]    err;
  assign stb_g    = gnt_o ? m1_stb_i : m0_stb_i;
  assign in_grant = (state == GRANT);
  assign s_stb_o  = in_grant && stb_g;
  assign s_adr_o  = gnt_o ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = gnt_o ? m1_dat_i : m0_dat_i;
  assign s_we_o   = gnt_o ? m1_we_i : m0_we_i;
  assign s_byte_o = gnt_o ? m1_byte_i : m0_byte_i;
  assign m0_ack_o = s_ack_i && in_grant && !gnt_o;
  assign m1_ack_o = s_ack_i && in_grant && gnt_o;
  assign m0_err_o = err[0];
  assign m1_err_o = err[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  mem_arb_pick #(.PRIO_MODE(PRIO_MODE), .STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .stb0(m0_stb_i),
    .stb1(m1_stb_i),
    .last_gnt(last_gnt),
    .starve_cnt(starve_cnt),
    .win(win)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state      <= IDLE;
      gnt_o      <= 1'b0;
      last_gnt   <= 1'b1;
      starve_cnt <= '0;
      wdog       <= '0;
      err        <= '0;
    end else begin
      err <= '0;
      case (state)
        IDLE: begin
          if (m0_stb_i || m1_stb_i) begin
            state    <= GRANT;
            gnt_o    <= win;
            last_gnt <= win;
            wdog     <= '0;
          end
          starve_cnt <= (!m1_stb_i || win) ? '0 :
                        (starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
        end
        GRANT: begin
          wdog <= wdog + 1'b1;
          if (s_ack_i || !stb_g) state <= RELEASE;
          else if (wdog == WW'(TIMEOUT - 1)) begin
            state <= RELEASE;
            err   <= gnt_o ? 2'b10 : 2'b01;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
